// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, FSM encoding and sizing helper for mem_arbiter
package mem_arbiter_pkg;

    localparam logic CLI_ICACHE = 1'b0;
    localparam logic CLI_DCACHE = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    // Counter/pointer width; never below 1 so single-beat configs still elaborate.
    function automatic int ceil_log2(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two cache clients plus one main-memory port bundled as one interface
//   master : arbiter view (drives ready/resp to clients, request/data to memory)
//   slave  : environment view (caches and memory model)
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic [1:0]                 cli_req_val;
    logic [1:0]                 cli_req_rdy;
    logic [2*ADDR_BITS-1:0]     cli_req_addr;
    logic [1:0]                 cli_req_rw;
    logic [1:0]                 cli_req_data_valid;
    logic [1:0]                 cli_req_data_ready;
    logic [2*DATA_BITS-1:0]     cli_req_data_bits;
    logic [2*DATA_BITS/8-1:0]   cli_req_data_mask;
    logic [1:0]                 cli_resp_val;
    logic                       mem_req_val;
    logic                       mem_req_rdy;
    logic [ADDR_BITS-1:0]       mem_req_addr;
    logic                       mem_req_rw;
    logic                       mem_req_data_valid;
    logic                       mem_req_data_ready;
    logic [DATA_BITS-1:0]       mem_req_data_bits;
    logic [DATA_BITS/8-1:0]     mem_req_data_mask;
    logic                       mem_resp_val;

    modport master (
        input  cli_req_val, cli_req_addr, cli_req_rw, cli_req_data_valid,
               cli_req_data_bits, cli_req_data_mask, mem_req_rdy,
               mem_req_data_ready, mem_resp_val,
        output cli_req_rdy, cli_req_data_ready, cli_resp_val, mem_req_val,
               mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask
    );

    modport slave (
        output cli_req_val, cli_req_addr, cli_req_rw, cli_req_data_valid,
               cli_req_data_bits, cli_req_data_mask, mem_req_rdy,
               mem_req_data_ready, mem_resp_val,
        input  cli_req_rdy, cli_req_data_ready, cli_resp_val, mem_req_val,
               mem_req_addr, mem_req_rw, mem_req_data_valid,
               mem_req_data_bits, mem_req_data_mask
    );
endinterface

// File: rtl/mem_arbiter_owner_fifo.sv
// owner_fifo: 1-bit-wide FIFO recording which client owns each outstanding read
//   clk, reset (async active-low); push/din write the tail; pop drops head;
//   full, empty, head reflect registered state.
import mem_arbiter_pkg::*;

module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = ceil_log2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wp, rp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            if (push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
        end
    end

    // Extra pointer bit separates a wrapped (full) FIFO from an empty one.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: icache/dcache arbiter onto one main-memory request/data channel
//   clk, reset (async active-low); bus = mem_arbiter_if.master carrying both
//   client ports and the memory port. Define ARB_RR_EN for round-robin grant;
//   otherwise dcache has fixed priority over icache.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_BITS   = 28,
    parameter int DATA_BITS   = 128,
    parameter int BEATS       = 4,
    parameter int OWNER_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int CW = ceil_log2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_t         state, state_nx;
    logic           wowner;
    logic [CW-1:0]  wcnt, rcnt;
    logic           full, empty, head;
    logic [1:0]     elig;
    logic           g, rw_g, hs, beat, rbeat, pop;

    // A read is only eligible while there is room to remember its owner.
    assign elig  = bus.cli_req_val & (bus.cli_req_rw | {2{~full}});
    assign rw_g  = g ? bus.cli_req_rw[1] : bus.cli_req_rw[0];
    assign hs    = (state == IDLE) && (|elig) && bus.mem_req_rdy;
    assign beat  = (state == WDATA) && bus.mem_req_data_ready &&
                   (wowner ? bus.cli_req_data_valid[1] : bus.cli_req_data_valid[0]);
    assign rbeat = bus.mem_resp_val && !empty;
    assign pop   = rbeat && (rcnt == LAST);

`ifdef ARB_RR_EN
    // rr_ptr holds the client served last; on a tie the other one wins.
    logic rr_ptr;
    assign g = (&elig) ? ~rr_ptr : elig[CLI_DCACHE];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr <= CLI_ICACHE;
        else if (hs) rr_ptr <= g;
    end
`else
    assign g = elig[CLI_DCACHE];
`endif

    owner_fifo #(.DEPTH(OWNER_DEPTH)) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs && !rw_g),
        .pop   (pop),
        .din   (g),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wowner <= CLI_ICACHE;
            wcnt   <= '0;
            rcnt   <= '0;
        end else begin
            state <= state_nx;
            if (hs && rw_g) begin
                wowner <= g;
                wcnt   <= '0;
            end else if (beat) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
            end
            if (rbeat) rcnt <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
        end
    end

    // Outputs are forced to zero while reset is held, even with clients active.
    always_comb begin
        state_nx                = state;
        bus.cli_req_rdy         = '0;
        bus.cli_req_data_ready  = '0;
        bus.cli_resp_val        = '0;
        bus.mem_req_val         = 1'b0;
        bus.mem_req_addr        = '0;
        bus.mem_req_rw          = 1'b0;
        bus.mem_req_data_valid  = 1'b0;
        bus.mem_req_data_bits   = '0;
        bus.mem_req_data_mask   = '0;
        if (reset) begin
            bus.cli_resp_val[head] = rbeat;
            if (state == IDLE) begin
                bus.mem_req_val    = |elig;
                bus.mem_req_addr   = g ? bus.cli_req_addr[2*ADDR_BITS-1:ADDR_BITS]
                                       : bus.cli_req_addr[ADDR_BITS-1:0];
                bus.mem_req_rw     = rw_g;
                bus.cli_req_rdy[g] = (|elig) && bus.mem_req_rdy;
                if (hs && rw_g) state_nx = WDATA;
            end else begin
                bus.mem_req_data_valid = wowner ? bus.cli_req_data_valid[1]
                                                : bus.cli_req_data_valid[0];
                bus.mem_req_data_bits  = wowner ? bus.cli_req_data_bits[2*DATA_BITS-1:DATA_BITS]
                                                : bus.cli_req_data_bits[DATA_BITS-1:0];
                bus.mem_req_data_mask  = wowner ? bus.cli_req_data_mask[2*DATA_BITS/8-1:DATA_BITS/8]
                                                : bus.cli_req_data_mask[DATA_BITS/8-1:0];
                bus.cli_req_data_ready[wowner] = bus.mem_req_data_ready;
                if (beat && wcnt == LAST) state_nx = IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (reads, writes, full FIFO, arbitration, reset)
module tb_mem_arbiter;
    localparam int AB = 28;
    localparam int DB = 128;
    localparam int MB = DB / 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .BEATS(4), .OWNER_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int nchk = 0;
    int nfail = 0;
    logic own_q[$];
    logic [DB-1:0] wq[$];
    int rbeats = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cli_req_val = '0;
        bus.cli_req_addr = '0;
        bus.cli_req_rw = '0;
        bus.cli_req_data_valid = '0;
        bus.cli_req_data_bits = '0;
        bus.cli_req_data_mask = '0;
        bus.mem_req_rdy = 1'b1;
        bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_val = 1'b0;
    endtask

    // Drive n response beats; each must go to the owner at the head of own_q.
    task automatic resp_beats(input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            bus.mem_resp_val = 1'b1;
            #1;
            e = (own_q.size() > 0) ? (2'b01 << own_q[0]) : 2'b00;
            nchk++;
            if (bus.cli_resp_val !== e) begin nfail++; $display("FAIL resp_route: got %0b want %0b", bus.cli_resp_val, e); end
            if (own_q.size() > 0 && ++rbeats == 4) begin void'(own_q.pop_front()); rbeats = 0; end
            tick();
        end
        bus.mem_resp_val = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.cli_req_val = 2'b11;
        bus.cli_req_data_valid = 2'b11;
        bus.mem_req_data_ready = 1'b1;
        bus.mem_resp_val = 1'b1;
        #1;
        nchk++; if (bus.mem_req_val !== 1'b0) begin nfail++; $display("FAIL rst_mem_req_val: got %0b want 0", bus.mem_req_val); end
        nchk++; if (bus.cli_req_rdy !== 2'b00) begin nfail++; $display("FAIL rst_cli_req_rdy: got %0b want 0", bus.cli_req_rdy); end
        nchk++; if (bus.cli_resp_val !== 2'b00) begin nfail++; $display("FAIL rst_cli_resp_val: got %0b want 0", bus.cli_resp_val); end
        nchk++; if (bus.cli_req_data_ready !== 2'b00) begin nfail++; $display("FAIL rst_data_ready: got %0b want 0", bus.cli_req_data_ready); end
        idle_inputs();
        tick();
        reset = 1'b1;
        #1;
        nchk++; if (bus.mem_req_val !== 1'b0) begin nfail++; $display("FAIL idle_no_req: got %0b want 0", bus.mem_req_val); end
        tick();
    endtask

    task automatic test_icache_read();
        idle_inputs();
        bus.cli_req_val = 2'b01;
        bus.cli_req_addr[AB-1:0] = 28'h10;
        #1;
        nchk++; if (bus.mem_req_val !== 1'b1) begin nfail++; $display("FAIL ird_val: got %0b want 1", bus.mem_req_val); end
        nchk++; if (bus.mem_req_addr !== 28'h10) begin nfail++; $display("FAIL ird_addr: got %0h want 10", bus.mem_req_addr); end
        nchk++; if (bus.mem_req_rw !== 1'b0) begin nfail++; $display("FAIL ird_rw: got %0b want 0", bus.mem_req_rw); end
        nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL ird_rdy: got %0b want 01", bus.cli_req_rdy); end
        own_q.push_back(1'b0);
        tick();
        bus.cli_req_val = 2'b00;
        resp_beats(4);
        bus.mem_resp_val = 1'b1;
        #1;
        nchk++; if (bus.cli_resp_val !== 2'b00) begin nfail++; $display("FAIL empty_resp: got %0b want 00", bus.cli_resp_val); end
        tick();
        bus.mem_resp_val = 1'b0;
    endtask

    task automatic test_both_read();
        idle_inputs();
        bus.cli_req_val = 2'b11;
        bus.cli_req_addr = {28'h200, 28'h100};
        #1;
        nchk++; if (bus.cli_req_rdy !== 2'b10) begin nfail++; $display("FAIL both_first_rdy: got %0b want 10", bus.cli_req_rdy); end
        nchk++; if (bus.mem_req_addr !== 28'h200) begin nfail++; $display("FAIL both_first_addr: got %0h want 200", bus.mem_req_addr); end
        own_q.push_back(1'b1);
        tick();
        bus.cli_req_val = 2'b01;
        #1;
        nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL both_second_rdy: got %0b want 01", bus.cli_req_rdy); end
        nchk++; if (bus.mem_req_addr !== 28'h100) begin nfail++; $display("FAIL both_second_addr: got %0h want 100", bus.mem_req_addr); end
        own_q.push_back(1'b0);
        tick();
        bus.cli_req_val = 2'b00;
        resp_beats(8);
    endtask

    task automatic test_write();
        logic [DB-1:0] d[4];
        logic rdy_seq[5];
        int idx;
        d = '{128'hA, 128'hB, 128'hC, 128'hD};
        rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        idle_inputs();
        bus.cli_req_val = 2'b11;
        bus.cli_req_rw = 2'b10;
        bus.cli_req_addr = {28'h20, 28'h30};
        bus.cli_req_data_valid = 2'b11;
        bus.cli_req_data_bits = {d[0], 128'h55};
        bus.cli_req_data_mask = {{MB{1'b1}}, {MB{1'b0}}};
        bus.mem_req_data_ready = 1'b1;
        #1;
        nchk++; if (bus.cli_req_rdy !== 2'b10) begin nfail++; $display("FAIL wr_grant_rdy: got %0b want 10", bus.cli_req_rdy); end
        nchk++; if (bus.mem_req_addr !== 28'h20) begin nfail++; $display("FAIL wr_addr: got %0h want 20", bus.mem_req_addr); end
        nchk++; if (bus.mem_req_rw !== 1'b1) begin nfail++; $display("FAIL wr_rw: got %0b want 1", bus.mem_req_rw); end
        nchk++; if (bus.cli_req_data_ready !== 2'b00) begin nfail++; $display("FAIL wr_early_hold: got %0b want 00", bus.cli_req_data_ready); end
        for (int i = 0; i < 4; i++) wq.push_back(d[i]);
        tick();
        bus.cli_req_val = 2'b01;
        bus.cli_req_rw = 2'b00;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.mem_req_data_ready = rdy_seq[c];
            bus.cli_req_data_bits[2*DB-1:DB] = d[idx];
            #1;
            nchk++; if (bus.cli_req_rdy !== 2'b00) begin nfail++; $display("FAIL wd_req_hold c%0d: got %0b want 00", c, bus.cli_req_rdy); end
            nchk++; if (bus.mem_req_data_valid !== 1'b1) begin nfail++; $display("FAIL wd_valid c%0d: got %0b want 1", c, bus.mem_req_data_valid); end
            nchk++; if (bus.mem_req_data_bits !== wq[0]) begin nfail++; $display("FAIL wd_bits c%0d: got %0h want %0h", c, bus.mem_req_data_bits, wq[0]); end
            nchk++; if (bus.mem_req_data_mask !== {MB{1'b1}}) begin nfail++; $display("FAIL wd_mask c%0d: got %0h want all ones", c, bus.mem_req_data_mask); end
            nchk++; if (bus.cli_req_data_ready !== {rdy_seq[c], 1'b0}) begin nfail++; $display("FAIL wd_ready c%0d: got %0b want %0b", c, bus.cli_req_data_ready, {rdy_seq[c], 1'b0}); end
            if (rdy_seq[c]) begin void'(wq.pop_front()); idx++; end
            tick();
        end
        #1;
        nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL wr_after_rdy: got %0b want 01", bus.cli_req_rdy); end
        nchk++; if (bus.cli_req_data_ready !== 2'b00) begin nfail++; $display("FAIL wr_after_dready: got %0b want 00", bus.cli_req_data_ready); end
        own_q.push_back(1'b0);
        tick();
        idle_inputs();
        resp_beats(4);
    endtask

    task automatic test_fifo_full();
        logic [1:0] e;
        idle_inputs();
        bus.cli_req_val = 2'b01;
        for (int i = 0; i < 4; i++) begin
            bus.cli_req_addr[AB-1:0] = 28'h40 + 28'(i);
            #1;
            nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL fill_rdy %0d: got %0b want 01", i, bus.cli_req_rdy); end
            own_q.push_back(1'b0);
            tick();
        end
        #1;
        nchk++; if (bus.mem_req_val !== 1'b0) begin nfail++; $display("FAIL full_val: got %0b want 0", bus.mem_req_val); end
        nchk++; if (bus.cli_req_rdy !== 2'b00) begin nfail++; $display("FAIL full_rdy: got %0b want 00", bus.cli_req_rdy); end
        for (int b = 0; b < 4; b++) begin
            bus.mem_resp_val = 1'b1;
            #1;
            e = 2'b01 << own_q[0];
            nchk++; if (bus.cli_resp_val !== e) begin nfail++; $display("FAIL full_resp %0d: got %0b want %0b", b, bus.cli_resp_val, e); end
            nchk++; if (bus.mem_req_val !== 1'b0) begin nfail++; $display("FAIL full_hold %0d: got %0b want 0", b, bus.mem_req_val); end
            if (++rbeats == 4) begin void'(own_q.pop_front()); rbeats = 0; end
            tick();
        end
        bus.mem_resp_val = 1'b0;
        #1;
        nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL refill_rdy: got %0b want 01", bus.cli_req_rdy); end
        own_q.push_back(1'b0);
        tick();
        bus.cli_req_val = 2'b00;
        resp_beats(16);
    endtask

    task automatic test_arbitration();
        logic g_exp[4];
        logic [1:0] e;
`ifdef ARB_RR_EN
        g_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        g_exp = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        idle_inputs();
        bus.cli_req_val = 2'b11;
        bus.cli_req_addr = {28'h300, 28'h400};
        for (int i = 0; i < 4; i++) begin
            #1;
            e = 2'b01 << g_exp[i];
            nchk++; if (bus.cli_req_rdy !== e) begin nfail++; $display("FAIL arb_grant %0d: got %0b want %0b", i, bus.cli_req_rdy, e); end
            own_q.push_back(g_exp[i]);
            tick();
        end
        bus.cli_req_val = 2'b00;
        resp_beats(16);
    endtask

    task automatic test_reset_mid_write();
        idle_inputs();
        bus.cli_req_val = 2'b01;
        #1;
        tick();
        bus.cli_req_val = 2'b10;
        bus.cli_req_rw = 2'b10;
        bus.cli_req_addr = {28'h80, 28'h90};
        bus.cli_req_data_valid = 2'b10;
        bus.cli_req_data_bits = {128'h1234, 128'h0};
        bus.cli_req_data_mask = {{MB{1'b1}}, {MB{1'b0}}};
        bus.mem_req_data_ready = 1'b1;
        #1;
        tick();
        bus.cli_req_val = 2'b01;
        bus.cli_req_rw = 2'b00;
        #1;
        tick();
        reset = 1'b0;
        bus.mem_resp_val = 1'b1;
        #1;
        nchk++; if (bus.mem_req_data_valid !== 1'b0) begin nfail++; $display("FAIL mrst_dvalid: got %0b want 0", bus.mem_req_data_valid); end
        nchk++; if (bus.cli_req_data_ready !== 2'b00) begin nfail++; $display("FAIL mrst_dready: got %0b want 00", bus.cli_req_data_ready); end
        nchk++; if (bus.mem_req_data_bits !== '0) begin nfail++; $display("FAIL mrst_bits: got %0h want 0", bus.mem_req_data_bits); end
        nchk++; if (bus.mem_req_val !== 1'b0) begin nfail++; $display("FAIL mrst_val: got %0b want 0", bus.mem_req_val); end
        nchk++; if (bus.cli_req_rdy !== 2'b00) begin nfail++; $display("FAIL mrst_rdy: got %0b want 00", bus.cli_req_rdy); end
        nchk++; if (bus.cli_resp_val !== 2'b00) begin nfail++; $display("FAIL mrst_resp: got %0b want 00", bus.cli_resp_val); end
        own_q.delete();
        rbeats = 0;
        tick();
        reset = 1'b1;
        #1;
        nchk++; if (bus.cli_resp_val !== 2'b00) begin nfail++; $display("FAIL post_rst_empty: got %0b want 00", bus.cli_resp_val); end
        nchk++; if (bus.cli_req_rdy !== 2'b01) begin nfail++; $display("FAIL post_rst_idle: got %0b want 01", bus.cli_req_rdy); end
        nchk++; if (bus.cli_req_data_ready !== 2'b00) begin nfail++; $display("FAIL post_rst_dready: got %0b want 00", bus.cli_req_data_ready); end
        own_q.push_back(1'b0);
        tick();
        idle_inputs();
        resp_beats(4);
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_both_read();
        test_write();
        test_fifo_full();
        test_arbitration();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
